z80_bus_arbiter: RTL and testbench

- Sequential arbiter that owns the master-select input of the system bus multiplexer.
- Master 0 is always the Z80 CPU and is the default (parked) owner.
- Masters 1..MASTER_QTY-1 (DMA and similar engines) request the bus. The arbiter takes the bus from the CPU through the Z80 BUSREQ/BUSACK handshake, grants it round-robin, and returns it to the CPU when no requests remain.

---
 rtl/z80_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
`timescale 1ns/1ps
// z80_bus_arbiter: parks the system bus on the Z80 (master 0) and lends it to the
// other masters round-robin through BUSREQ/BUSACK. Optional macro: ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
  parameter int MASTER_QTY     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW = (MASTER_QTY > 2) ? $clog2(MASTER_QTY) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASTER_QTY-1:0] req,
  output logic [MASTER_QTY-1:0] gnt,
  output logic [SW-1:0]         msel,
  output logic                  busreq_n,
  input  logic                  busack_n,
  input  logic                  bus_idle,
  output logic                  arb_err,
  output logic [2:0]            dbg_state_o
);

  if (MASTER_QTY < 2 || MASTER_QTY > 16) begin : g_bad_master_qty
    $error("MASTER_QTY must be within 2..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  // Handshake: a master holds req until it sees its gnt bit, then drops req to
  // hand the bus back; the bus only moves on once bus_idle shows no cycle in flight.
  typedef enum logic [2:0] {
    ST_CPU     = 3'd0,
    ST_REQ     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] winner_q, winner_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          ack_meta_q, ack_sync_q;
  logic          ack;
  logic          any_req;
  logic [SW:0]   pick;

  // First requester at or after p, wrapping from MASTER_QTY-1 back to 1.
  function automatic logic [SW:0] rr_pick(input logic [MASTER_QTY-1:0] r,
                                          input logic [SW-1:0] p);
    logic [SW:0]   res;
    logic [SW-1:0] cand;
    int            idx;
    res = '0;
    for (int i = 0; i < MASTER_QTY - 1; i++) begin
      idx = int'(p) + i;
      if (idx >= MASTER_QTY) idx = idx - (MASTER_QTY - 1);
      cand = SW'(idx);
      if (!res[SW] && r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] w);
    return (w == SW'(MASTER_QTY - 1)) ? SW'(1) : w + SW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
    end else begin
      ack_meta_q <= busack_n;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign ack     = ~ack_sync_q;
  assign any_req = |req[MASTER_QTY-1:1];
  assign pick    = rr_pick(req, ptr_q);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign cnt_d   = (state_q == ST_REQ) ? cnt_q + 16'd1 : 16'd0;
  assign arb_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign arb_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    gnt      = '0;
    msel     = '0;
    busreq_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_CPU: begin
        gnt = MASTER_QTY'(1);
        if (any_req) begin
          winner_d = pick[SW-1:0];
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        gnt      = MASTER_QTY'(1);
        busreq_n = 1'b0;
        if (!req[winner_q]) begin
          if (any_req) winner_d = pick[SW-1:0];
          else         state_d  = ST_RELEASE;
        end else if (ack) begin
          ptr_d   = rr_next(winner_q);
          state_d = ST_GRANT;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter may overshoot while re-picking, so compare with >=.
        else if (cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          ptr_d   = rr_next(winner_q);
          state_d = ST_CPU;
        end
`endif
      end
      ST_GRANT: begin
        gnt      = MASTER_QTY'(1) << winner_q;
        msel     = winner_q;
        busreq_n = 1'b0;
        if (!req[winner_q] && bus_idle) state_d = any_req ? ST_SWITCH : ST_RELEASE;
      end
      ST_SWITCH: begin
        msel     = winner_q;
        busreq_n = 1'b0;
        if (pick[SW]) begin
          winner_d = pick[SW-1:0];
          ptr_d    = rr_next(pick[SW-1:0]);
          state_d  = ST_GRANT;
        end else begin
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (ack_sync_q) state_d = ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CPU;
      winner_q <= '0;
      ptr_q    <= SW'(1);
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for z80_bus_arbiter (3 masters): directed scenarios plus random traffic,
// compared every cycle with a behavioural bus-ownership model.
module tb_z80_bus_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   msel;
  logic         busreq_n;
  logic         busack_n = 1'b1;
  logic         bus_idle = 1'b1;
  logic         arb_err;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  z80_bus_arbiter #(.MASTER_QTY(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .msel(msel),
    .busreq_n(busreq_n), .busack_n(busack_n), .bus_idle(bus_idle),
    .arb_err(arb_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = CPU holds bus, k>0 = master k holds bus, -1 = nobody.
  // breq: BUSREQ asserted. sel: mux select. want: master being asked for.
  int owner = 0, sel = 0, want = 0, rr = 1, tcnt = 0;
  bit breq = 0, err = 0;
  bit ackh[$] = '{1'b1, 1'b1};

  function automatic int model_pick(logic [N-1:0] r, int start);
    for (int k = 0; k < N - 1; k++) begin
      int m;
      m = ((start - 1 + k) % (N - 1)) + 1;
      if (r[m]) return m;
    end
    return -1;
  endfunction

  function automatic int after(int w);
    return (w % (N - 1)) + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0; sel = 0; want = 0; rr = 1; tcnt = 0; breq = 0; err = 0;
      ackh.delete(); ackh.push_back(1'b1); ackh.push_back(1'b1);
    end else begin
      bit ack_n_seen;
      int p;
      ack_n_seen = ackh.pop_front();
      ackh.push_back(busack_n);
      p = model_pick(req, rr);
      if (owner == 0 && !breq) begin
        if (p > 0) begin want = p; breq = 1; tcnt = 0; end
      end else if (owner == 0) begin
        if (!req[want]) begin
          if (p > 0) want = p;
          else begin owner = -1; breq = 0; sel = 0; end
        end else if (!ack_n_seen) begin
          owner = want; sel = want; rr = after(want);
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt + 1 >= TO) begin
          err = 1; breq = 0; rr = after(want);
        end
`endif
        tcnt++;
      end else if (owner > 0) begin
        if (!req[owner] && bus_idle) begin
          owner = -1;
          if (p <= 0) begin breq = 0; sel = 0; end
        end
      end else if (breq) begin
        if (p > 0) begin owner = p; sel = p; rr = after(p); end
        else begin breq = 0; sel = 0; end
      end else begin
        if (ack_n_seen) owner = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] eg;
      eg = (owner >= 0) ? (N'(1) << owner) : '0;
      chk("model_gnt", gnt, eg);
      chk("model_msel", msel, 32'(sel));
      chk("model_busreq_n", busreq_n, !breq);
      chk("model_arb_err", arb_err, err);
      chk("gnt_onehot0", ($countones(gnt) <= 1), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; bus_idle = 1'b1; busack_n = 1'b1;
    #1;
    chk("rst_gnt", gnt, 3'b001);
    chk("rst_msel", msel, 0);
    chk("rst_busreq_n", busreq_n, 1);
    chk("rst_arb_err", arb_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input logic [N-1:0] exp, input int budget, input string name);
    int n;
    n = 0;
    while (gnt !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int hold[N];
  logic [N-1:0] prev;
  int got;

  initial begin
    // single master, delayed BUSACK
    do_reset();
    req = 3'b010;
    tick();
    chk("t2_busreq_fall", busreq_n, 0);
    chk("t2_cpu_keeps", gnt, 3'b001);
    tick(); tick();
    busack_n = 1'b0;
    tick(); tick();
    chk("t2_sync_wait", gnt, 3'b001);
    tick();
    chk("t2_gnt_m1", gnt, 3'b010);
    chk("t2_msel_m1", msel, 1);
    req = 3'b000; bus_idle = 1'b1;
    tick();
    chk("t2_release_breq", busreq_n, 1);
    chk("t2_release_gnt", gnt, 3'b000);
    busack_n = 1'b1;
    tick(); tick();
    chk("t2_wait_ack_rise", gnt, 3'b000);
    tick();
    chk("t2_back_cpu", gnt, 3'b001);

    // two masters, switch with dead cycle
    do_reset();
    req = 3'b110; busack_n = 1'b0;
    wait_gnt(3'b010, 10, "t3_first_m1");
    req = 3'b100;
    tick();
    chk("t3_gap_gnt", gnt, 3'b000);
    chk("t3_gap_msel", msel, 1);
    tick();
    chk("t3_gnt_m2", gnt, 3'b100);
    chk("t3_msel_m2", msel, 2);
    req = 3'b000;
    tick();
    chk("t3_release_breq", busreq_n, 1);
    busack_n = 1'b1;
    wait_gnt(3'b001, 10, "t3_back_cpu");

    // no handover while the bus is busy
    do_reset();
    req = 3'b100; busack_n = 1'b0;
    wait_gnt(3'b100, 10, "t4_gnt_m2");
    req = 3'b010; bus_idle = 1'b0;
    repeat (4) begin
      tick();
      chk("t4_hold_busy", gnt, 3'b100);
    end
    bus_idle = 1'b1;
    tick();
    chk("t4_gap", gnt, 3'b000);
    tick();
    chk("t4_gnt_m1", gnt, 3'b010);

    // winner withdraws before BUSACK: re-pick, then abort
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b100;
    tick();
    chk("t_repick_breq", busreq_n, 0);
    busack_n = 1'b0;
    wait_gnt(3'b100, 10, "t_repick_m2");
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    chk("t_abort_breq", busreq_n, 1);
    chk("t_abort_gnt", gnt, 3'b000);
    wait_gnt(3'b001, 10, "t_abort_cpu");

    // fairness: both masters keep coming back
    do_reset();
    req = 3'b110; busack_n = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 4'd1 : 4'd2);
    prev = gnt;
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      tick();
      if (gnt != prev && (gnt == 3'b010 || gnt == 3'b100)) begin
        got = (gnt == 3'b010) ? 1 : 2;
        chk("t5_rr_order", got, exp_q.pop_front());
      end
      prev = gnt;
      for (int i = 1; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = 1'b1;
      end
    end
    chk("t5_all_grants_seen", exp_q.size(), 0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 3'b010;
    repeat (8) tick();
    chk("t6_no_err_yet", arb_err, 0);
    tick();
    chk("t6_err", arb_err, 1);
    chk("t6_breq", busreq_n, 1);
    chk("t6_gnt_cpu", gnt, 3'b001);
    req = 3'b110; busack_n = 1'b0;
    wait_gnt(3'b100, 12, "t6_next_m2");
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      bus_idle = ($urandom_range(0, 2) != 0);
      if (busack_n != busreq_n && $urandom_range(0, 2) == 0) busack_n = busreq_n;
      for (int i = 1; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 4) == 0) req[i] = 1'b1;
        end else if (gnt[i]) begin
          if (hold[i] == 0) req[i] = 1'b0;
          else hold[i]--;
        end else begin
          hold[i] = $urandom_range(0, 3);
        end
      end
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
